// File: rtl/transaction_sequencer_pkg.sv
// Shared constants for the coin-transfer sequencer: state codes, memory map, result codes.
// Used by the sequencer, the main controller and the display logic.
// Pure declarations; no logic, no timing.
package transaction_sequencer_pkg;

  // FSM state encoding
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_INIT      = 4'd1;
  localparam state_t ST_INIT_DONE = 4'd2;
  localparam state_t ST_RD_KEY    = 4'd3;
  localparam state_t ST_CHK_KEY   = 4'd4;
  localparam state_t ST_RD_SRC    = 4'd5;
  localparam state_t ST_CHK_SRC   = 4'd6;
  localparam state_t ST_RD_DST    = 4'd7;
  localparam state_t ST_CHK_DST   = 4'd8;
  localparam state_t ST_WR_DST    = 4'd9;
  localparam state_t ST_WR_SRC    = 4'd10;
  localparam state_t ST_DONE      = 4'd11;

  // Balance/key memory map
  typedef logic [1:0] addr_t;
  localparam addr_t ADDR_P1_BAL = 2'd0;
  localparam addr_t ADDR_P2_BAL = 2'd1;
  localparam addr_t ADDR_P1_KEY = 2'd2;
  localparam addr_t ADDR_P2_KEY = 2'd3;

  // Transaction result codes
  typedef logic [1:0] result_t;
  localparam result_t RES_OK       = 2'b00;
  localparam result_t RES_BAD_KEY  = 2'b01;
  localparam result_t RES_NO_FUNDS = 2'b10;
  localparam result_t RES_OVERFLOW = 2'b11;

  // sender 0 means P1 pays P2; sender 1 means P2 pays P1
  function automatic addr_t src_addr(input logic sender);
    return sender ? ADDR_P2_BAL : ADDR_P1_BAL;
  endfunction

  function automatic addr_t dst_addr(input logic sender);
    return sender ? ADDR_P1_BAL : ADDR_P2_BAL;
  endfunction

  function automatic addr_t key_addr(input logic sender);
    return sender ? ADDR_P2_KEY : ADDR_P1_KEY;
  endfunction

endpackage

// File: rtl/transaction_sequencer.sv
// Sequences one all-or-nothing coin transfer (key, funds, overflow checks then two writes) or the init image.
// Transfer: DONE at E+3/E+5/E+7/E+9 for bad key/no funds/overflow/OK; init: writes I+1..I+4, init_done I+5.
// Level handshake: start_transaction held until finished_transaction; requests while busy wait for IDLE.
module transaction_sequencer
  import transaction_sequencer_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_BALANCE = DATA_WIDTH'(100),
  parameter logic [DATA_WIDTH-1:0] P1_KEY       = DATA_WIDTH'(8'hA5),
  parameter logic [DATA_WIDTH-1:0] P2_KEY       = DATA_WIDTH'(8'h5A)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  init_memory,
  input  logic                  start_transaction,
  input  logic                  sender,
  input  logic [DATA_WIDTH-1:0] amount,
  input  logic [DATA_WIDTH-1:0] key,
  input  logic [1:0]            disp_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  init_done,
  output logic                  finished_transaction,
  output logic [1:0]            result
);

  state_t                state_q, state_d;
  logic                  sender_q, sender_d;
  logic [DATA_WIDTH-1:0] amount_q, amount_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] new_src_q, new_src_d;
  logic [DATA_WIDTH-1:0] new_dst_q, new_dst_d;
  result_t               result_q, result_d;

  // One extra bit so an overflowing destination balance shows up as a carry
  logic [DATA_WIDTH:0]   dst_sum;
  assign dst_sum = {1'b0, mem_rdata} + {1'b0, amount_q};

  // Power-up image, in address order
  function automatic logic [DATA_WIDTH-1:0] init_word(input logic [1:0] a);
    case (a)
      ADDR_P1_BAL: return INIT_BALANCE;
      ADDR_P2_BAL: return INIT_BALANCE;
      ADDR_P1_KEY: return P1_KEY;
      default:     return P2_KEY;
    endcase
  endfunction

  // Next-state logic and memory-port mux; the display owns the port only while idle
  always_comb begin
    state_d   = state_q;
    sender_d  = sender_q;
    amount_d  = amount_q;
    key_d     = key_q;
    cnt_d     = cnt_q;
    new_src_d = new_src_q;
    new_dst_d = new_dst_q;
    result_d  = result_q;
    mem_addr  = disp_addr;
    mem_we    = 1'b0;
    mem_wdata = '0;

    case (state_q)
      ST_IDLE: begin
        if (init_memory) begin
          cnt_d   = 2'd0;
          state_d = ST_INIT;
        end else if (start_transaction) begin
          sender_d = sender;
          amount_d = amount;
          key_d    = key;
          result_d = RES_OK;
          state_d  = ST_RD_KEY;
        end
      end

      ST_INIT: begin
        mem_addr  = cnt_q;
        mem_we    = 1'b1;
        mem_wdata = init_word(cnt_q);
        cnt_d     = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = ST_INIT_DONE;
        end
      end

      ST_INIT_DONE: begin
        mem_addr = cnt_q;
        state_d  = ST_IDLE;
      end

      ST_RD_KEY: begin
        mem_addr = key_addr(sender_q);
        state_d  = ST_CHK_KEY;
      end

      ST_CHK_KEY: begin
        mem_addr = key_addr(sender_q);
        if (mem_rdata != key_q) begin
          result_d = RES_BAD_KEY;
          state_d  = ST_DONE;
        end else begin
          state_d  = ST_RD_SRC;
        end
      end

      ST_RD_SRC: begin
        mem_addr = src_addr(sender_q);
        state_d  = ST_CHK_SRC;
      end

      ST_CHK_SRC: begin
        mem_addr = src_addr(sender_q);
        if (mem_rdata < amount_q) begin
          result_d = RES_NO_FUNDS;
          state_d  = ST_DONE;
        end else begin
          new_src_d = mem_rdata - amount_q;
          state_d   = ST_RD_DST;
        end
      end

      ST_RD_DST: begin
        mem_addr = dst_addr(sender_q);
        state_d  = ST_CHK_DST;
      end

      ST_CHK_DST: begin
        mem_addr = dst_addr(sender_q);
        if (dst_sum[DATA_WIDTH]) begin
          result_d = RES_OVERFLOW;
          state_d  = ST_DONE;
        end else begin
          new_dst_d = dst_sum[DATA_WIDTH-1:0];
          state_d   = ST_WR_DST;
        end
      end

      // Every rejection has been decided by now, so writing is safe
      ST_WR_DST: begin
        mem_addr  = dst_addr(sender_q);
        mem_we    = 1'b1;
        mem_wdata = new_dst_q;
        state_d   = ST_WR_SRC;
      end

      ST_WR_SRC: begin
        mem_addr  = src_addr(sender_q);
        mem_we    = 1'b1;
        mem_wdata = new_src_q;
        result_d  = RES_OK;
        state_d   = ST_DONE;
      end

      ST_DONE: begin
        mem_addr = src_addr(sender_q);
        if (!start_transaction) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched request, init counter and computed balances
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sender_q  <= 1'b0;
      amount_q  <= '0;
      key_q     <= '0;
      cnt_q     <= 2'd0;
      new_src_q <= '0;
      new_dst_q <= '0;
      result_q  <= RES_OK;
    end else begin
      state_q   <= state_d;
      sender_q  <= sender_d;
      amount_q  <= amount_d;
      key_q     <= key_d;
      cnt_q     <= cnt_d;
      new_src_q <= new_src_d;
      new_dst_q <= new_dst_d;
      result_q  <= result_d;
    end
  end

  assign busy                 = (state_q != ST_IDLE);
  assign init_done            = (state_q == ST_INIT_DONE);
  assign finished_transaction = (state_q == ST_DONE);
  assign result               = result_q;

endmodule

// File: tb/tb_transaction_sequencer.sv
// Bench for transaction_sequencer: owns the balance/key memory, predicts outcomes from the transfer rules.
// Directed scenarios from the plan followed by randomized transfers against the reference model.
// Sampling happens 1 time unit after each rising edge.
module tb_transaction_sequencer;

  logic       clock = 1'b0;
  logic       reset, init_memory, start_transaction, sender;
  logic [7:0] amount, key, mem_rdata, mem_wdata;
  logic [1:0] disp_addr, mem_addr, result;
  logic       mem_we, busy, init_done, finished_transaction;

  always #5 clock = ~clock;

  transaction_sequencer dut (
    .clock(clock), .reset(reset), .init_memory(init_memory),
    .start_transaction(start_transaction), .sender(sender), .amount(amount),
    .key(key), .disp_addr(disp_addr), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .busy(busy), .init_done(init_done),
    .finished_transaction(finished_transaction), .result(result)
  );

  // Synchronous-read memory, plus a backdoor for preloading balances
  logic [7:0] mem [4];
  logic       bd_we = 1'b0;
  logic [1:0] bd_addr = 2'd0;
  logic [7:0] bd_data = 8'd0;
  always @(posedge clock) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int tests = 0;
  int fails = 0;
  int model_mem [4];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input int a, input int v);
    bd_we = 1'b1; bd_addr = 2'(a); bd_data = 8'(v);
    step();
    bd_we = 1'b0;
    model_mem[a] = v;
  endtask

  // Reference: decide outcome from the transfer rules and update the model memory
  task automatic predict(input logic s, input int amt, input int k,
                         output logic [1:0] res, output int lat);
    int src, dst;
    src = s ? 1 : 0;
    dst = 1 - src;
    if (k != model_mem[2 + src]) begin res = 2'b01; lat = 3; end
    else if (model_mem[src] < amt) begin res = 2'b10; lat = 5; end
    else if (model_mem[dst] + amt > 255) begin res = 2'b11; lat = 7; end
    else begin
      res = 2'b00; lat = 9;
      model_mem[src] = model_mem[src] - amt;
      model_mem[dst] = model_mem[dst] + amt;
    end
  endtask

  // Runs until DONE (or a 40-cycle bound); lat is the cycle index after E, 0 on timeout
  task automatic run_txn(input logic s, input logic [7:0] amt, input logic [7:0] k,
                         output logic [1:0] res, output int lat, output bit we_seen);
    sender = s; amount = amt; key = k; start_transaction = 1'b1;
    lat = 0; we_seen = 1'b0;
    step();
    sender = ~s; amount = 8'($urandom); key = 8'($urandom);
    for (int c = 1; c <= 40; c++) begin
      if (mem_we) we_seen = 1'b1;
      if (finished_transaction) begin lat = c; break; end
      step();
    end
    res = result;
  endtask

  // Keeps start high one more cycle, then drops it; reports hold and fall
  task automatic end_txn(output bit held, output bit fell);
    step();
    held = finished_transaction;
    start_transaction = 1'b0;
    step();
    fell = !finished_transaction;
  endtask

  task automatic test_reset();
    reset = 1'b1; init_memory = 1'b0; start_transaction = 1'b0;
    sender = 1'b0; amount = 8'd0; key = 8'd0; disp_addr = 2'd2;
    step(); step();
    tests++;
    if ({busy, mem_we, init_done, finished_transaction} !== 4'b0000 || mem_wdata !== 8'd0 || result !== 2'b00) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b we=%b done=%b fin=%b wdata=%h res=%b, required all zero",
               busy, mem_we, init_done, finished_transaction, mem_wdata, result);
    end
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      disp_addr = 2'(a);
      step();
      tests++;
      if (mem_addr !== 2'(a) || mem_we !== 1'b0) begin
        fails++;
        $display("FAIL idle_disp_addr: mem_addr=%0d we=%b, required %0d/0", mem_addr, mem_we, a);
      end
    end
  endtask

  task automatic test_init();
    logic [7:0] exp_data [4];
    exp_data[0] = 8'd100; exp_data[1] = 8'd100; exp_data[2] = 8'hA5; exp_data[3] = 8'h5A;
    init_memory = 1'b1;
    step();
    init_memory = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c <= 4) begin
        tests++;
        if (mem_we !== 1'b1 || mem_addr !== 2'(c - 1) || mem_wdata !== exp_data[c-1]) begin
          fails++;
          $display("FAIL init_write_%0d: we=%b addr=%0d data=%h, required 1/%0d/%h",
                   c, mem_we, mem_addr, mem_wdata, c - 1, exp_data[c-1]);
        end
      end
      tests++;
      if (init_done !== (c == 5)) begin
        fails++;
        $display("FAIL init_done_cycle_%0d: init_done=%b, required %b", c, init_done, c == 5);
      end
      step();
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL init_busy_after: busy=%b, required 0", busy);
    end
    model_mem[0] = 100; model_mem[1] = 100; model_mem[2] = 'hA5; model_mem[3] = 'h5A;
    for (int a = 0; a < 4; a++) begin
      tests++;
      if (mem[a] !== 8'(model_mem[a])) begin
        fails++;
        $display("FAIL init_mem_%0d: got %h, required %h", a, mem[a], 8'(model_mem[a]));
      end
    end
  endtask

  task automatic test_ok_transfer();
    logic [1:0] res, eres; int lat, elat; bit we, held, fell;
    predict(1'b0, 30, 'hA5, eres, elat);
    run_txn(1'b0, 8'd30, 8'hA5, res, lat, we);
    tests++;
    if (res !== eres || lat != elat) begin
      fails++;
      $display("FAIL ok_result: res=%b lat=%0d, required %b/%0d", res, lat, eres, elat);
    end
    end_txn(held, fell);
    tests++;
    if (!held || !fell) begin
      fails++;
      $display("FAIL ok_handshake: held=%0d fell=%0d, required 1/1", held, fell);
    end
    tests++;
    if (mem[0] !== 8'd70 || mem[1] !== 8'd130 || model_mem[0] != 70) begin
      fails++;
      $display("FAIL ok_balances: P1=%0d P2=%0d, required 70/130", mem[0], mem[1]);
    end
  endtask

  task automatic test_bad_key();
    logic [1:0] res; int lat; bit we, held, fell;
    run_txn(1'b1, 8'd10, 8'hA5, res, lat, we);
    end_txn(held, fell);
    tests++;
    if (res !== 2'b01 || lat != 3 || we) begin
      fails++;
      $display("FAIL bad_key: res=%b lat=%0d we_seen=%0d, required 01/3/0", res, lat, we);
    end
    tests++;
    if (mem[0] !== 8'd70 || mem[1] !== 8'd130) begin
      fails++;
      $display("FAIL bad_key_balances: P1=%0d P2=%0d, required 70/130", mem[0], mem[1]);
    end
  endtask

  task automatic test_no_funds();
    logic [1:0] res; int lat; bit we, held, fell;
    run_txn(1'b0, 8'd71, 8'hA5, res, lat, we);
    end_txn(held, fell);
    tests++;
    if (res !== 2'b10 || lat != 5 || we) begin
      fails++;
      $display("FAIL no_funds: res=%b lat=%0d we_seen=%0d, required 10/5/0", res, lat, we);
    end
    run_txn(1'b0, 8'd70, 8'hA5, res, lat, we);
    end_txn(held, fell);
    model_mem[0] = 0; model_mem[1] = 200;
    tests++;
    if (res !== 2'b00 || lat != 9 || mem[0] !== 8'd0 || mem[1] !== 8'd200) begin
      fails++;
      $display("FAIL exact_funds: res=%b lat=%0d P1=%0d P2=%0d, required 00/9/0/200",
               res, lat, mem[0], mem[1]);
    end
  endtask

  task automatic test_overflow();
    logic [1:0] res; int lat; bit we, held, fell;
    preload(0, 100);
    preload(1, 250);
    run_txn(1'b0, 8'd6, 8'hA5, res, lat, we);
    end_txn(held, fell);
    tests++;
    if (res !== 2'b11 || lat != 7 || we || mem[1] !== 8'd250) begin
      fails++;
      $display("FAIL overflow: res=%b lat=%0d we_seen=%0d P2=%0d, required 11/7/0/250",
               res, lat, we, mem[1]);
    end
    run_txn(1'b0, 8'd5, 8'hA5, res, lat, we);
    end_txn(held, fell);
    model_mem[0] = 95; model_mem[1] = 255;
    tests++;
    if (res !== 2'b00 || lat != 9 || mem[0] !== 8'd95 || mem[1] !== 8'd255) begin
      fails++;
      $display("FAIL max_dst: res=%b lat=%0d P1=%0d P2=%0d, required 00/9/95/255",
               res, lat, mem[0], mem[1]);
    end
  endtask

  task automatic test_reset_midway();
    preload(0, 100);
    preload(1, 100);
    sender = 1'b0; amount = 8'd20; key = 8'hA5; start_transaction = 1'b1;
    step();
    step(); step(); step();
    reset = 1'b1;
    step();
    tests++;
    if ({busy, mem_we, init_done, finished_transaction} !== 4'b0000 || mem_wdata !== 8'd0 ||
        result !== 2'b00 || mem_addr !== disp_addr) begin
      fails++;
      $display("FAIL midway_reset: busy=%b we=%b fin=%b wdata=%h res=%b addr=%0d, required idle values",
               busy, mem_we, finished_transaction, mem_wdata, result, mem_addr);
    end
    start_transaction = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 8; c++) step();
    tests++;
    if (mem[0] !== 8'd100 || mem[1] !== 8'd100 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midway_mem: P1=%0d P2=%0d busy=%b, required 100/100/0", mem[0], mem[1], busy);
    end
  endtask

  task automatic test_init_priority();
    bit seen_done;
    preload(0, 7);
    init_memory = 1'b1; start_transaction = 1'b1; sender = 1'b0; amount = 8'd1; key = 8'hA5;
    step();
    init_memory = 1'b0; start_transaction = 1'b0;
    tests++;
    if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== 8'd100) begin
      fails++;
      $display("FAIL init_priority: we=%b addr=%0d data=%h, required 1/0/64", mem_we, mem_addr, mem_wdata);
    end
    seen_done = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      if (init_done) seen_done = 1'b1;
      step();
    end
    step();
    model_mem[0] = 100; model_mem[1] = 100; model_mem[2] = 'hA5; model_mem[3] = 'h5A;
    tests++;
    if (!seen_done || mem[0] !== 8'd100 || busy !== 1'b0 || finished_transaction !== 1'b0) begin
      fails++;
      $display("FAIL init_priority_end: done=%0d P1=%0d busy=%b fin=%b, required 1/100/0/0",
               seen_done, mem[0], busy, finished_transaction);
    end
  endtask

  task automatic test_random();
    logic [1:0] res, eres; int lat, elat; bit we, held, fell;
    logic s; logic [7:0] amt, k;
    for (int n = 0; n < 40; n++) begin
      if (n % 8 == 0) begin
        preload(0, int'($urandom_range(0, 255)));
        preload(1, int'($urandom_range(0, 255)));
      end
      s = 1'($urandom);
      amt = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 160));
      k = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(model_mem[2 + int'(s)]);
      predict(s, int'(amt), int'(k), eres, elat);
      run_txn(s, amt, k, res, lat, we);
      end_txn(held, fell);
      tests++;
      if (res !== eres || lat != elat || (eres != 2'b00 && we) || !held || !fell) begin
        fails++;
        $display("FAIL rand_%0d: res=%b lat=%0d we=%0d held=%0d fell=%0d, required %b/%0d",
                 n, res, lat, we, held, fell, eres, elat);
      end
      tests++;
      if (mem[0] !== 8'(model_mem[0]) || mem[1] !== 8'(model_mem[1])) begin
        fails++;
        $display("FAIL rand_mem_%0d: P1=%0d P2=%0d, required %0d/%0d",
                 n, mem[0], mem[1], model_mem[0], model_mem[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_ok_transfer();
    test_bad_key();
    test_no_funds();
    test_overflow();
    test_reset_midway();
    test_init_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
